// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one hex-to-seven-segment decoder. Each digit is preceded by an
// all-dark blanking gap so the segment lines can settle without ghosting.
// New display values enter a shadow register through a valid/ready
// handshake. They are copied to the active register only at a frame
// boundary, so one frame never mixes old and new digits.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       scan enable; low keeps the display dark
//   value        packed nibbles, nibble i = value[4i+3:4i]
//   dp_in        per-digit decimal-point request, captured with value
//   value_valid  load request
//   value_ready  shadow register empty (a load is accepted on valid&&ready)
//   lz_suppress  leading-zero suppression, sampled live
//   hex          nibble to the shared decoder
//   an           anode enables, active-low
//   dp           decimal point, active-low
//   digit_idx    index of the selected digit
//   frame_done   one-cycle pulse after the last digit's SHOW phase
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 2000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [4*NUM_DIGITS-1:0]       value,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          value_valid,
   output logic                          value_ready,
   input  logic                          lz_suppress,
   output logic [3:0]                    hex,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          dp,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]   active_q, active_d;
   logic [NUM_DIGITS-1:0]        dp_act_q, dp_act_d;
   logic [NUM_DIGITS-1:0][3:0]   shadow_q;
   logic [NUM_DIGITS-1:0]        shadow_dp_q;
   logic                         shadow_full_q, shadow_full_d;
   logic                         boundary;
   logic                         accept;
   logic                         xfer;

   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic                         dp_q, dp_d;
   logic [3:0]                   hex_q, hex_d;
   logic                         ready_q;
   logic                         frame_done_q;

   logic [NUM_DIGITS-1:1]        nib_zero;
   logic [NUM_DIGITS-1:0]        lz_blank;
   logic                         zero_run;

   // ---------------- sequencing FSM ----------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      boundary = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = SHOW;
                  cnt_d   = '0;
               end
            end
            SHOW: begin
               if (cnt_q == DIGIT_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  if (idx_q == LAST_IDX) begin
                     idx_d    = '0;
                     boundary = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // ---------------- handshake / shadow transfer ----------------
   // accept and xfer are mutually exclusive: accept needs an empty shadow,
   // xfer needs a full one, both judged at the start of the cycle.
   assign accept = value_valid && ready_q;
   assign xfer   = shadow_full_q && (boundary || (state_q == IDLE));

   always_comb begin
      shadow_full_d = shadow_full_q;
      if (accept) begin
         shadow_full_d = 1'b1;
      end else if (xfer) begin
         shadow_full_d = 1'b0;
      end
      active_d = xfer ? shadow_q    : active_q;
      dp_act_d = xfer ? shadow_dp_q : dp_act_q;
   end

   // ---------------- leading-zero suppression ----------------
   // Outputs are registered from next-state values, so the zero test looks
   // at active_d; a freshly transferred value is judged correctly on the
   // first cycle of its frame.
   for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (active_d[gi] == 4'h0);
   end

   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run & nib_zero[i];
         lz_blank[i] = lz_suppress & zero_run;
      end
   end

   // ---------------- output decode (next-state) ----------------
   always_comb begin
      an_d  = '1;
      dp_d  = 1'b1;
      hex_d = active_d[idx_d];
      if ((state_d == SHOW) && !lz_blank[idx_d]) begin
         an_d[idx_d] = 1'b0;
         dp_d        = ~dp_act_d[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         active_q      <= '0;
         dp_act_q      <= '0;
         shadow_q      <= '0;
         shadow_dp_q   <= '0;
         shadow_full_q <= 1'b0;
         an_q          <= '1;
         dp_q          <= 1'b1;
         hex_q         <= 4'h0;
         ready_q       <= 1'b1;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         active_q      <= active_d;
         dp_act_q      <= dp_act_d;
         shadow_full_q <= shadow_full_d;
         if (accept) begin
            shadow_q    <= value;
            shadow_dp_q <= dp_in;
         end
         an_q          <= an_d;
         dp_q          <= dp_d;
         hex_q         <= hex_d;
         ready_q       <= ~shadow_full_d;
         frame_done_q  <= boundary;
      end
   end

   assign an          = an_q;
   assign dp          = dp_q;
   assign hex         = hex_q;
   assign digit_idx   = idx_q;
   assign value_ready = ready_q;
   assign frame_done  = frame_done_q;

endmodule
